// File: rtl/coord_lcd_pkg.sv
// Shared types and constants for the coordinate-to-LCD text feeder.
// COORD_LCD_HEX_EN selects the 3-digit hex frame instead of the 4-digit decimal one.
package coord_lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_CONV,
        ST_EMIT,
        ST_STROBE,
        ST_GAP
    } state_t;

    localparam logic [7:0] CH_X  = 8'h58;
    localparam logic [7:0] CH_Y  = 8'h59;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_A  = 8'h41;

    localparam int FRAME_DEC = 11;
    localparam int FRAME_HEX = 9;
    localparam int BCD_MAX   = 9999;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? CH_0 + {4'h0, nib} : CH_A + {4'h0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/coord_lcd_feeder_if.sv
// Detector-side update port plus LCD-controller-side request outputs of the feeder.
interface coord_lcd_feeder_if #(
    parameter int COORD_W = 10
);
    logic               upd_valid;
    logic [COORD_W-1:0] upd_x;
    logic [COORD_W-1:0] upd_y;
    logic               write_req;
    logic               delete_req;
    logic [7:0]         inbyte;
    logic               busy;

    modport master (
        input  upd_valid, upd_x, upd_y,
        output write_req, delete_req, inbyte, busy
    );

    modport slave (
        output upd_valid, upd_x, upd_y,
        input  write_req, delete_req, inbyte, busy
    );
endinterface

// File: rtl/coord_lcd_feeder_bin2bcd.sv
// Sequential binary-to-BCD by repeated subtraction of 1000/100/10, input clamped to 9999.
module bin2bcd_seq
    import coord_lcd_pkg::*;
#(
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic               i_start,
    input  logic [COORD_W-1:0] i_val,
    output logic               o_done,
    output logic [3:0][3:0]    o_bcd
);

    logic            r_run;
    logic            r_done;
    logic [13:0]     r_rem;
    logic [1:0]      r_pos;
    logic [3:0][3:0] r_bcd;
    logic [13:0]     w_wt;
    logic [31:0]     w_val;

    assign w_val  = 32'(i_val);
    assign w_wt   = (r_pos == 2'd3) ? 14'd1000 : (r_pos == 2'd2) ? 14'd100 : 14'd10;
    assign o_done = r_done;
    assign o_bcd  = r_bcd;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_run  <= 1'b0;
            r_done <= 1'b0;
            r_rem  <= '0;
            r_pos  <= 2'd3;
            r_bcd  <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem <= (w_val > 32'(BCD_MAX)) ? 14'(BCD_MAX) : w_val[13:0];
                r_pos <= 2'd3;
                r_bcd <= '0;
                r_run <= 1'b1;
            end else if (r_run) begin
                if (r_rem >= w_wt) begin
                    r_rem        <= r_rem - w_wt;
                    r_bcd[r_pos] <= r_bcd[r_pos] + 4'd1;
                end else if (r_pos == 2'd1) begin
                    // remainder below 10 is the units digit
                    r_bcd[0] <= r_rem[3:0];
                    r_run    <= 1'b0;
                    r_done   <= 1'b1;
                end else begin
                    r_pos <= r_pos - 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/coord_lcd_feeder.sv
// Turns ball coordinates into a paced "Xdddd Ydddd" toggle-request stream for the LCD controller.
// Define COORD_LCD_HEX_EN for the "Xhhh Yhhh" hex frame (no BCD conversion).
module coord_lcd_feeder
    import coord_lcd_pkg::*;
#(
    parameter int GAP_CYCLES = 20000,
    parameter int COORD_W    = 10
) (
    input  logic                clk,
    input  logic                res_n,
    coord_lcd_feeder_if.master  bus
);

    localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int GW      = $clog2(GAP_EFF + 1);

    state_t             r_state, n_state;
    logic [COORD_W-1:0] r_x, n_x, r_y, n_y;
    logic [COORD_W-1:0] r_sx, n_sx, r_sy, n_sy;
    logic               r_pend, n_pend;
    logic               r_busy, n_busy;
    logic               r_wr, n_wr;
    logic               r_del, n_del;
    logic [7:0]         r_byte, n_byte;
    logic [GW-1:0]      r_gap, n_gap;
    logic [3:0]         r_idx, n_idx;
    logic [7:0]         w_char;

`ifdef COORD_LCD_HEX_EN
    localparam logic [3:0] FRAME_LEN = 4'(FRAME_HEX);
    logic [11:0] w_hx, w_hy;

    assign w_hx = 12'(r_x);
    assign w_hy = 12'(r_y);

    always_comb begin
        w_char = CH_SP;
        case (r_idx)
            4'd0:    w_char = CH_X;
            4'd1:    w_char = hex_ascii(w_hx[11:8]);
            4'd2:    w_char = hex_ascii(w_hx[7:4]);
            4'd3:    w_char = hex_ascii(w_hx[3:0]);
            4'd5:    w_char = CH_Y;
            4'd6:    w_char = hex_ascii(w_hy[11:8]);
            4'd7:    w_char = hex_ascii(w_hy[7:4]);
            4'd8:    w_char = hex_ascii(w_hy[3:0]);
            default: w_char = CH_SP;
        endcase
    end
`else
    localparam logic [3:0] FRAME_LEN = 4'(FRAME_DEC);
    logic               w_start;
    logic               w_done;
    logic [3:0][3:0]    w_bcd;
    logic [COORD_W-1:0] w_cval;

    // one converter serves both values; x digits are consumed before y is converted
    assign w_cval = (r_idx == 4'd1) ? r_x : r_y;

    bin2bcd_seq #(.COORD_W(COORD_W)) u_bcd (
        .clk     (clk),
        .res_n   (res_n),
        .i_start (w_start),
        .i_val   (w_cval),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    always_comb begin
        w_char = CH_SP;
        case (r_idx)
            4'd0:        w_char = CH_X;
            4'd6:        w_char = CH_Y;
            4'd1, 4'd7:  w_char = CH_0 + {4'h0, w_bcd[3]};
            4'd2, 4'd8:  w_char = CH_0 + {4'h0, w_bcd[2]};
            4'd3, 4'd9:  w_char = CH_0 + {4'h0, w_bcd[1]};
            4'd4, 4'd10: w_char = CH_0 + {4'h0, w_bcd[0]};
            default:     w_char = CH_SP;
        endcase
    end
`endif

    assign bus.write_req  = r_wr;
    assign bus.delete_req = r_del;
    assign bus.inbyte     = r_byte;
    assign bus.busy       = r_busy;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_sx    <= '0;
            r_sy    <= '0;
            r_pend  <= 1'b0;
            r_busy  <= 1'b0;
            r_wr    <= 1'b0;
            r_del   <= 1'b0;
            r_byte  <= CH_SP;
            r_gap   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= n_state;
            r_x     <= n_x;
            r_y     <= n_y;
            r_sx    <= n_sx;
            r_sy    <= n_sy;
            r_pend  <= n_pend;
            r_busy  <= n_busy;
            r_wr    <= n_wr;
            r_del   <= n_del;
            r_byte  <= n_byte;
            r_gap   <= n_gap;
            r_idx   <= n_idx;
        end
    end

    always_comb begin
        n_state = r_state;
        n_x     = r_x;
        n_y     = r_y;
        n_sx    = r_sx;
        n_sy    = r_sy;
        n_pend  = r_pend;
        n_busy  = r_busy;
        n_wr    = r_wr;
        n_del   = r_del;
        n_byte  = r_byte;
        n_gap   = r_gap;
        n_idx   = r_idx;
`ifndef COORD_LCD_HEX_EN
        w_start = 1'b0;
`endif

        if (r_state == ST_IDLE && r_pend)
            n_pend = 1'b0;
        // an update not consumed straight from IDLE lands in the shadow; latest wins
        if (bus.upd_valid && !(r_state == ST_IDLE && !r_pend)) begin
            n_sx   = bus.upd_x;
            n_sy   = bus.upd_y;
            n_pend = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (r_pend || bus.upd_valid) begin
                    n_x     = r_pend ? r_sx : bus.upd_x;
                    n_y     = r_pend ? r_sy : bus.upd_y;
                    n_busy  = 1'b1;
                    n_idx   = '0;
                    n_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                n_del   = ~r_del;
                n_gap   = GW'(GAP_EFF);
                n_state = ST_GAP;
            end
            ST_CONV: begin
`ifndef COORD_LCD_HEX_EN
                if (w_done)
                    n_state = ST_EMIT;
`else
                n_state = ST_EMIT;
`endif
            end
            ST_EMIT: begin
                n_byte  = w_char;
                n_state = ST_STROBE;
            end
            ST_STROBE: begin
                n_wr    = ~r_wr;
                n_idx   = r_idx + 4'd1;
                n_gap   = GW'(GAP_EFF);
                n_state = ST_GAP;
            end
            ST_GAP: begin
                if (r_gap != '0) begin
                    n_gap = r_gap - GW'(1);
                end else if (r_idx == FRAME_LEN) begin
                    n_busy  = 1'b0;
                    n_state = ST_IDLE;
`ifndef COORD_LCD_HEX_EN
                end else if (r_idx == 4'd1 || r_idx == 4'd7) begin
                    w_start = 1'b1;
                    n_state = ST_CONV;
`endif
                end else begin
                    n_state = ST_EMIT;
                end
            end
            default: n_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_coord_lcd_feeder.sv
// Directed bench for coord_lcd_feeder: frame content, pacing, update buffering, reset.
// Expected frames follow COORD_LCD_HEX_EN when the bench is built with it.
module tb_coord_lcd_feeder;
    localparam int GAP = 8;
    localparam int CW  = 10;

    logic clk;
    logic res_n;

    coord_lcd_feeder_if #(.COORD_W(CW)) intf ();

    coord_lcd_feeder #(.GAP_CYCLES(GAP), .COORD_W(CW)) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (intf.master)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] ev_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // toggle monitor: records every request edge, checks pacing and inbyte setup
    initial begin
        logic pw, pd;
        logic [7:0] pb;
        int cyc, last;
        logic wt, dt;
        pw = 0; pd = 0; pb = 8'h20; cyc = 0; last = -1000;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!res_n) begin
                pw = 0; pd = 0; last = -1000;
            end else begin
                wt = (intf.write_req != pw);
                dt = (intf.delete_req != pd);
                if (wt || dt) begin
                    chk("one_toggle", 32'(wt && dt), 32'd0);
                    chk("spacing", 32'((cyc - last) >= GAP + 1), 32'd1);
                    last = cyc;
                end
                if (wt) begin
                    chk("byte_setup", 32'(intf.inbyte == pb), 32'd1);
                    ev_q.push_back({1'b0, intf.inbyte});
                end
                if (dt) ev_q.push_back(9'h100);
                pw = intf.write_req;
                pd = intf.delete_req;
            end
            pb = intf.inbyte;
        end
    end

    task automatic send(input int x, input int y);
        @(negedge clk);
        intf.upd_valid = 1'b1;
        intf.upd_x     = CW'(x);
        intf.upd_y     = CW'(y);
        @(negedge clk);
        intf.upd_valid = 1'b0;
    endtask

    task automatic wait_busy(input string tag, input logic lvl, input int lim);
        int k = 0;
        while (intf.busy !== lvl && k < lim) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk(tag, 32'(intf.busy), 32'(lvl));
    endtask

    task automatic wait_ev(input string tag, input int n, input int lim);
        int k = 0;
        while (ev_q.size() < n && k < lim) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk(tag, 32'(ev_q.size() >= n), 32'd1);
    endtask

    task automatic check_frame(input string tag, input string exp);
        chk({tag, "_nev"}, 32'(ev_q.size()), 32'(exp.len() + 1));
        if (ev_q.size() > 0) chk({tag, "_del"}, 32'(ev_q[0]), 32'h100);
        for (int i = 0; i < exp.len(); i++)
            if (i + 1 < ev_q.size())
                chk($sformatf("%s_ch%0d", tag, i), 32'(ev_q[i+1]), 32'({1'b0, exp[i]}));
    endtask

    initial begin
        string f1, f5, f3, fb, fe1, fe2, fr;
`ifdef COORD_LCD_HEX_EN
        f1 = "X280 Y1DF"; f5 = "X005 Y006"; f3 = "X003 Y004"; fb = "X000 Y3FF";
        fe1 = "X00C Y022"; fe2 = "X038 Y04E"; fr = "X2AF Y1E0";
`else
        f1 = "X0640 Y0479"; f5 = "X0005 Y0006"; f3 = "X0003 Y0004"; fb = "X0000 Y1023";
        fe1 = "X0012 Y0034"; fe2 = "X0056 Y0078"; fr = "X0687 Y0480";
`endif
        res_n = 1'b0;
        intf.upd_valid = 1'b0;
        intf.upd_x = '0;
        intf.upd_y = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_wr", 32'(intf.write_req), 32'd0);
        chk("rst_del", 32'(intf.delete_req), 32'd0);
        chk("rst_byte", 32'(intf.inbyte), 32'h20);
        chk("rst_busy", 32'(intf.busy), 32'd0);
        @(negedge clk) res_n = 1'b1;

        // basic frame
        ev_q.delete();
        send(640, 479);
        wait_busy("f1_busy_hi", 1'b1, 50);
        wait_busy("f1_busy_lo", 1'b0, 3000);
        check_frame("f1", f1);

        // busy buffering: only the latest of two mid-frame updates is shown
        ev_q.delete();
        send(5, 6);
        repeat (30) @(posedge clk);
        send(1, 2);
        repeat (30) @(posedge clk);
        send(3, 4);
        wait_busy("buf_lo", 1'b0, 3000);
        check_frame("buf_a", f5);
        ev_q.delete();
        wait_busy("buf_hi2", 1'b1, 50);
        wait_busy("buf_lo2", 1'b0, 3000);
        check_frame("buf_b", f3);
        ev_q.delete();
        repeat (300) @(posedge clk);
        #2;
        chk("buf_idle", 32'(intf.busy), 32'd0);
        chk("buf_noextra", 32'(ev_q.size()), 32'd0);

        // boundary values
        ev_q.delete();
        send(0, 1023);
        wait_busy("bnd_hi", 1'b1, 50);
        wait_busy("bnd_lo", 1'b0, 3000);
        check_frame("bnd", fb);

        // update arriving on the frame-end cycle
        ev_q.delete();
        send(12, 34);
        wait_ev("fe_last", fe1.len() + 1, 3000);
        repeat (8) @(posedge clk);
        #2;
        intf.upd_valid = 1'b1;
        intf.upd_x = CW'(56);
        intf.upd_y = CW'(78);
        @(posedge clk);
        #2;
        intf.upd_valid = 1'b0;
        chk("fe_busy_lo", 32'(intf.busy), 32'd0);
        @(posedge clk);
        #2;
        chk("fe_busy_hi", 32'(intf.busy), 32'd1);
        check_frame("fe_a", fe1);
        ev_q.delete();
        wait_busy("fe_lo2", 1'b0, 3000);
        check_frame("fe_b", fe2);

        // reset in the middle of a frame
        ev_q.delete();
        send(687, 480);
        wait_ev("mid_4wr", 5, 3000);
        res_n = 1'b0;
        #1;
        chk("mid_wr", 32'(intf.write_req), 32'd0);
        chk("mid_del", 32'(intf.delete_req), 32'd0);
        chk("mid_busy", 32'(intf.busy), 32'd0);
        chk("mid_byte", 32'(intf.inbyte), 32'h20);
        repeat (3) @(posedge clk);
        @(negedge clk) res_n = 1'b1;
        ev_q.delete();
        repeat (300) @(posedge clk);
        #2;
        chk("mid_quiet", 32'(ev_q.size()), 32'd0);
        chk("mid_idle", 32'(intf.busy), 32'd0);

        // recovery frame with the same coordinates
        ev_q.delete();
        send(687, 480);
        wait_busy("rec_hi", 1'b1, 50);
        wait_busy("rec_lo", 1'b0, 3000);
        check_frame("rec", fr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
